pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Central stall scheduler for the 5-stage MIPS pipeline.
- Merges the ID-stage load-use stall request with the EX-stage divide sequencing and drives the 6-bit stall vector to PC/IF/ID/EX/MEM/WB.
- Owns the start/annul/result handshake with the iterative divider core.
- Returns the divide result to EX and pulses div_ready_to_id so ID can release its held instruction.

Parameters:
- DIV_CNT_W, 6, width of the divide-busy cycle counter.
- DIV_TIMEOUT, 40, busy-cycle limit; used only when DIV_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately, independent of clk.
- stallreq_from_id  in  1  load-use hazard request from ID; 1 = Stop.
- flush  in  1  kill the in-flight instruction in EX and abandon any divide.
- ex_div_op  in  1  EX holds div or divu.
- ex_div_signed  in  1  1 = div, 0 = divu.
- ex_div_src1  in  32  dividend.
- ex_div_src2  in  32  divisor.
- div_start  out  1  start request to the divider core, held high while busy.
- div_annul  out  1  one-cycle abort pulse to the divider core.
- div_signed  out  1  latched signedness.
- div_opdata1  out  32  latched dividend.
- div_opdata2  out  32  latched divisor.
- div_result_ready  in  1  divider core done, valid for one cycle.
- div_result  in  64  {remainder, quotient} from the divider core.
- stall  out  6  bit0 PC … bit5 WB; 1 = Stop.
- div_result_o  out  64  {hi, lo} result to EX.
- div_result_valid  out  1  div_result_o valid.
- div_ready_to_id  out  1  one-cycle pulse: divide finished, ID may release its held instruction.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0; all outputs 0 (stall=6'b000000).
- States: IDLE, BYZERO, ON, END; registered, 2-bit.
- IDLE:
  - If ex_div_op & ~flush & ex_div_src2==0 → BYZERO.
  - If ex_div_op & ~flush & ex_div_src2!=0 → ON; latch src1/src2/signed into div_opdata1/div_opdata2/div_signed.
  - Otherwise stay in IDLE.
- BYZERO: exactly one cycle; div_result_o <= 64'b0; → END.
- ON:
  - div_start=1 (registered, rises first cycle in ON); counter increments each cycle.
  - div_result_ready → latch div_result into div_result_o; → END.
  - flush → IDLE; div_start=0; div_annul=1 for exactly one cycle; counter cleared.
  - If flush and div_result_ready occur in the same cycle, flush wins and the result is discarded.
- END:
  - div_result_valid=1 and div_ready_to_id=1 for this single cycle; div_start=0.
  - → IDLE unconditionally.
  - ex_div_op is ignored in END: the same instruction is still in EX and must not restart.
- stallreq_ex (combinational) = (IDLE & ex_div_op & ~flush) | BYZERO | ON.
- Stall vector, with stallreq_ex taking priority over stallreq_from_id:
  - stallreq_ex=1 → stall=6'b001111.
  - else stallreq_from_id=1 → stall=6'b000111.
  - else stall=6'b000000.
- flush=1 forces stall=6'b000000 in the same cycle.
- Latency: a divide with the core ready after N cycles in ON holds EX for N+2 cycles (IDLE detect + N + END release). Divide-by-zero holds EX for 2 cycles.
- div_opdata*/div_signed hold their value outside ON; they update only on the IDLE→ON transition.
- Reset asserted mid-ON: the FSM drops to IDLE immediately, all outputs clear, no annul pulse is generated.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - In ON, counter==DIV_TIMEOUT-1 without div_result_ready → END with div_result_o=64'b0 and a one-cycle div_annul pulse.
  - Counter saturates; it never wraps.
- Undefined:
  - No timeout; ON waits indefinitely for div_result_ready.
  - The counter is still present and readable in simulation.

Test Plan:
- Load-use: stallreq_from_id=1 for 1 cycle, ex_div_op=0 → stall=6'b000111 that cycle, 6'b000000 the next.
- Normal divide: ex_div_op=1, signed=1, src1=32'hFFFFFFF9 (-7), src2=2, core ready 32 cycles after div_start.
  - Required: stall=6'b001111 for 34 cycles.
  - Required: div_result_o=64'hFFFFFFFF_FFFFFFFD (rem -1, quo -3) with div_result_valid and div_ready_to_id high for one cycle.
- Divide-by-zero: src2=0 → div_start never asserts; stall high 2 cycles; div_result_o=0; div_result_valid pulses in cycle 3.
- Flush mid-ON: flush on cycle 10 of ON → div_annul one cycle, div_start=0, stall=0 that cycle, state IDLE; a later div_result_ready is ignored.
- Simultaneous requests: stallreq_from_id=1 while ON → stall=6'b001111; in END with stallreq_from_id=1 → stall=6'b000111.
- Reset mid-ON: rst=0 asynchronously between clock edges → all outputs 0 before the next edge; with DIV_TIMEOUT_EN and DIV_TIMEOUT=40, a core that never responds → END after 40 ON cycles with result 0 and one annul pulse.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stall_ctrl
// Brief    : Pipeline stall scheduler merging the ID load-use request with EX
//            divide sequencing; owns the iterative divider handshake.
//            Optional busy-timeout abort enabled by macro DIV_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stall_ctrl #(
  parameter int DIV_CNT_W   = 6,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_from_id,
  input  logic        flush,
  input  logic        ex_div_op,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_div_src1,
  input  logic [31:0] ex_div_src2,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opdata1,
  output logic [31:0] div_opdata2,
  input  logic        div_result_ready,
  input  logic [63:0] div_result,
  output logic [5:0]  stall,
  output logic [63:0] div_result_o,
  output logic        div_result_valid,
  output logic        div_ready_to_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  // Counter stops at the timeout limit in every build so it can never wrap.
  localparam logic [DIV_CNT_W-1:0] c_CNT_LAST = DIV_CNT_W'(DIV_TIMEOUT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [DIV_CNT_W-1:0] w_cnt_nxt;
  logic                 w_start_nxt;
  logic                 w_annul_nxt;
  logic                 w_valid_nxt;
  logic                 w_ready_id_nxt;
  logic                 w_load_ops;
  logic [63:0]          w_res_nxt;
  logic                 w_stallreq_ex;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_start_nxt    = 1'b0;
    w_annul_nxt    = 1'b0;
    w_valid_nxt    = 1'b0;
    w_ready_id_nxt = 1'b0;
    w_load_ops     = 1'b0;
    w_res_nxt      = div_result_o;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (ex_div_op && !flush) begin
          if (ex_div_src2 == 32'd0) begin
            w_state_nxt = S_BYZERO;
          end else begin
            w_state_nxt = S_ON;
            w_start_nxt = 1'b1;
            w_load_ops  = 1'b1;
          end
        end
      end
      S_BYZERO: begin
        w_state_nxt    = S_END;
        w_res_nxt      = 64'd0;
        w_valid_nxt    = 1'b1;
        w_ready_id_nxt = 1'b1;
      end
      S_ON: begin
        w_start_nxt = 1'b1;
        if (r_cnt != c_CNT_LAST) w_cnt_nxt = r_cnt + 1'b1;
        // Flush outranks a same-cycle result: the instruction is gone.
        if (flush) begin
          w_state_nxt = S_IDLE;
          w_start_nxt = 1'b0;
          w_annul_nxt = 1'b1;
          w_cnt_nxt   = '0;
        end else if (div_result_ready) begin
          w_state_nxt    = S_END;
          w_start_nxt    = 1'b0;
          w_res_nxt      = div_result;
          w_valid_nxt    = 1'b1;
          w_ready_id_nxt = 1'b1;
        end
`ifdef DIV_TIMEOUT_EN
        else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt    = S_END;
          w_start_nxt    = 1'b0;
          w_annul_nxt    = 1'b1;
          w_res_nxt      = 64'd0;
          w_valid_nxt    = 1'b1;
          w_ready_id_nxt = 1'b1;
        end
`else
        else begin
          w_state_nxt = S_ON;
        end
`endif
      end
      S_END: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      div_start        <= 1'b0;
      div_annul        <= 1'b0;
      div_signed       <= 1'b0;
      div_opdata1      <= 32'd0;
      div_opdata2      <= 32'd0;
      div_result_o     <= 64'd0;
      div_result_valid <= 1'b0;
      div_ready_to_id  <= 1'b0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      div_start        <= w_start_nxt;
      div_annul        <= w_annul_nxt;
      div_result_o     <= w_res_nxt;
      div_result_valid <= w_valid_nxt;
      div_ready_to_id  <= w_ready_id_nxt;
      if (w_load_ops) begin
        div_signed  <= ex_div_signed;
        div_opdata1 <= ex_div_src1;
        div_opdata2 <= ex_div_src2;
      end
    end
  end

  // The EX request covers the detect cycle in IDLE so the divide is held
  // before the FSM has even left IDLE.
  assign w_stallreq_ex = (r_state == S_IDLE && ex_div_op && !flush) ||
                         (r_state == S_BYZERO) || (r_state == S_ON);

  always_comb begin
    stall = 6'b000000;
    if (!flush) begin
      if (w_stallreq_ex)         stall = 6'b001111;
      else if (stallreq_from_id) stall = 6'b000111;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// Directed self-checking bench for pipe_stall_ctrl.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_from_id = 1'b0;
  logic        flush = 1'b0;
  logic        ex_div_op = 1'b0;
  logic        ex_div_signed = 1'b0;
  logic [31:0] ex_div_src1 = 32'd0;
  logic [31:0] ex_div_src2 = 32'd0;
  logic        div_start;
  logic        div_annul;
  logic        div_signed;
  logic [31:0] div_opdata1;
  logic [31:0] div_opdata2;
  logic        div_result_ready = 1'b0;
  logic [63:0] div_result = 64'd0;
  logic [5:0]  stall;
  logic [63:0] div_result_o;
  logic        div_result_valid;
  logic        div_ready_to_id;

  int errors = 0;
  int checks = 0;

  pipe_stall_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_from_id(stallreq_from_id), .flush(flush),
    .ex_div_op(ex_div_op), .ex_div_signed(ex_div_signed),
    .ex_div_src1(ex_div_src1), .ex_div_src2(ex_div_src2),
    .div_start(div_start), .div_annul(div_annul), .div_signed(div_signed),
    .div_opdata1(div_opdata1), .div_opdata2(div_opdata2),
    .div_result_ready(div_result_ready), .div_result(div_result),
    .stall(stall), .div_result_o(div_result_o),
    .div_result_valid(div_result_valid), .div_ready_to_id(div_ready_to_id)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (stall !== 6'b0) begin errors++; $display("FAIL reset_stall: got %b expected 000000", stall); end
    checks++; if ({div_start, div_annul, div_result_valid, div_ready_to_id, div_signed} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {div_start, div_annul, div_result_valid, div_ready_to_id, div_signed}); end
    checks++; if ({div_result_o, div_opdata1, div_opdata2} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {div_result_o, div_opdata1, div_opdata2}); end
    tick(); rst = 1'b1; tick();
  endtask

  task automatic test_load_use();
    stallreq_from_id = 1'b1;
    @(negedge clk);
    checks++; if (stall !== 6'b000111) begin errors++; $display("FAIL load_use_on: got %b expected 000111", stall); end
    tick(); stallreq_from_id = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 6'b000000) begin errors++; $display("FAIL load_use_off: got %b expected 000000", stall); end
    tick();
  endtask

  // k=0 detect, k=1..33 ON (core ready 32 cycles after div_start), k=34 END.
  task automatic test_normal_div();
    int stall_cnt = 0;
    int valid_cnt = 0;
    ex_div_signed = 1'b1; ex_div_src1 = 32'hFFFFFFF9; ex_div_src2 = 32'd2;
    for (int k = 0; k <= 35; k++) begin
      ex_div_op = (k <= 34);
      div_result_ready = (k == 33);
      div_result = (k == 33) ? 64'hFFFFFFFF_FFFFFFFD : 64'h12345678_9ABCDEF0;
      @(negedge clk);
      if (stall === 6'b001111) stall_cnt++;
      if (div_result_valid === 1'b1) valid_cnt++;
      if (k == 0) begin
        checks++; if (div_start !== 1'b0) begin errors++; $display("FAIL div_start_detect: got %b expected 0", div_start); end
      end
      if (k == 1) begin
        checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL div_start_rise: got %b expected 1", div_start); end
        checks++; if ({div_signed, div_opdata1, div_opdata2} !== {1'b1, 32'hFFFFFFF9, 32'd2}) begin errors++; $display("FAIL div_operands: got %h expected 1fffffff900000002", {div_signed, div_opdata1, div_opdata2}); end
      end
      if (k == 34) begin
        checks++; if (div_result_o !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_result: got %h expected fffffffffffffffd", div_result_o); end
        checks++; if ({div_result_valid, div_ready_to_id, div_start, stall} !== {3'b110, 6'b0}) begin errors++; $display("FAIL div_end: got %b expected 110000000", {div_result_valid, div_ready_to_id, div_start, stall}); end
      end
      tick();
    end
    div_result_ready = 1'b0;
    checks++; if (stall_cnt !== 34) begin errors++; $display("FAIL div_stall_len: got %0d expected 34", stall_cnt); end
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL div_valid_len: got %0d expected 1", valid_cnt); end
  endtask

  task automatic test_div_by_zero();
    int start_seen = 0;
    ex_div_signed = 1'b0; ex_div_src1 = 32'd5; ex_div_src2 = 32'd0;
    for (int k = 0; k <= 3; k++) begin
      ex_div_op = (k <= 2);
      @(negedge clk);
      if (div_start === 1'b1) start_seen++;
      if (k <= 1) begin
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL dbz_stall k=%0d: got %b expected 001111", k, stall); end
      end
      if (k == 2) begin
        checks++; if ({div_result_valid, div_ready_to_id, stall} !== {2'b11, 6'b0}) begin errors++; $display("FAIL dbz_end: got %b expected 11000000", {div_result_valid, div_ready_to_id, stall}); end
        checks++; if (div_result_o !== 64'd0) begin errors++; $display("FAIL dbz_result: got %h expected 0", div_result_o); end
      end
      tick();
    end
    checks++; if (start_seen !== 0) begin errors++; $display("FAIL dbz_no_start: got %0d expected 0", start_seen); end
  endtask

  // Flush on the 10th ON cycle (k=10); a late core result must be ignored.
  task automatic test_flush();
    int annul_cnt = 0;
    ex_div_signed = 1'b0; ex_div_src1 = 32'd100; ex_div_src2 = 32'd7;
    for (int k = 0; k <= 14; k++) begin
      ex_div_op = (k <= 10);
      flush = (k == 10);
      div_result_ready = (k == 12);
      div_result = 64'h00000002_0000000E;
      @(negedge clk);
      if (div_annul === 1'b1) annul_cnt++;
      if (k == 10) begin
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL flush_stall: got %b expected 000000", stall); end
      end
      if (k == 11) begin
        checks++; if ({div_annul, div_start, stall} !== {2'b10, 6'b0}) begin errors++; $display("FAIL flush_annul: got %b expected 10000000", {div_annul, div_start, stall}); end
      end
      if (k == 13) begin
        checks++; if ({div_result_valid, div_ready_to_id} !== 2'b00 || div_result_o !== 64'd0) begin errors++; $display("FAIL flush_late_result: got %b/%h expected 00/0", {div_result_valid, div_ready_to_id}, div_result_o); end
      end
      tick();
    end
    div_result_ready = 1'b0;
    checks++; if (annul_cnt !== 1) begin errors++; $display("FAIL flush_annul_len: got %0d expected 1", annul_cnt); end
    checks++; if (div_opdata2 !== 32'd7) begin errors++; $display("FAIL flush_opdata2: got %h expected 7", div_opdata2); end
  endtask

  task automatic test_simultaneous();
    ex_div_signed = 1'b0; ex_div_src1 = 32'd9; ex_div_src2 = 32'd3;
    stallreq_from_id = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      ex_div_op = (k <= 4);
      stallreq_from_id = (k <= 4);
      div_result_ready = (k == 3);
      div_result = 64'h00000000_00000003;
      @(negedge clk);
      if (k == 0 || k == 2) begin
        checks++; if (stall !== 6'b001111) begin errors++; $display("FAIL simul_ex_prio k=%0d: got %b expected 001111", k, stall); end
      end
      if (k == 4) begin
        checks++; if ({stall, div_result_valid} !== {6'b000111, 1'b1}) begin errors++; $display("FAIL simul_end_id: got %b expected 0001111", {stall, div_result_valid}); end
        checks++; if (div_result_o !== 64'd3) begin errors++; $display("FAIL simul_result: got %h expected 3", div_result_o); end
      end
      if (k == 5) begin
        checks++; if (stall !== 6'b0) begin errors++; $display("FAIL simul_idle: got %b expected 000000", stall); end
      end
      tick();
    end
    div_result_ready = 1'b0;
  endtask

`ifdef DIV_TIMEOUT_EN
  // k=0 detect, k=1..40 ON with a silent core, k=41 END by timeout.
  task automatic test_timeout();
    int stall_cnt = 0;
    int annul_cnt = 0;
    ex_div_signed = 1'b1; ex_div_src1 = 32'd50; ex_div_src2 = 32'd5;
    for (int k = 0; k <= 43; k++) begin
      ex_div_op = (k <= 41);
      @(negedge clk);
      if (stall === 6'b001111) stall_cnt++;
      if (div_annul === 1'b1) annul_cnt++;
      if (k == 41) begin
        checks++; if ({div_result_valid, div_annul} !== 2'b11 || div_result_o !== 64'd0) begin errors++; $display("FAIL timeout_end: got %b/%h expected 11/0", {div_result_valid, div_annul}, div_result_o); end
      end
      tick();
    end
    checks++; if (stall_cnt !== 41) begin errors++; $display("FAIL timeout_stall_len: got %0d expected 41", stall_cnt); end
    checks++; if (annul_cnt !== 1) begin errors++; $display("FAIL timeout_annul_len: got %0d expected 1", annul_cnt); end
  endtask
`else
  // Without the timeout a silent core keeps the pipeline stalled indefinitely.
  task automatic test_timeout();
    int stall_cnt = 0;
    ex_div_signed = 1'b1; ex_div_src1 = 32'd50; ex_div_src2 = 32'd5;
    for (int k = 0; k <= 62; k++) begin
      ex_div_op = (k <= 60);
      flush = (k == 60);
      @(negedge clk);
      if (stall === 6'b001111) stall_cnt++;
      if (k == 61) begin
        checks++; if ({div_annul, div_result_valid} !== 2'b10) begin errors++; $display("FAIL no_timeout_abort: got %b expected 10", {div_annul, div_result_valid}); end
      end
      tick();
    end
    flush = 1'b0;
    checks++; if (stall_cnt !== 60) begin errors++; $display("FAIL no_timeout_stall_len: got %0d expected 60", stall_cnt); end
  endtask
`endif

  task automatic test_reset_mid_on();
    ex_div_signed = 1'b1; ex_div_src1 = 32'd77; ex_div_src2 = 32'd5;
    ex_div_op = 1'b1;
    tick(); tick();
    @(negedge clk);
    checks++; if (div_start !== 1'b1) begin errors++; $display("FAIL rst_pre_on: got %b expected 1", div_start); end
    #2; rst = 1'b0; ex_div_op = 1'b0;
    #1;
    checks++; if ({stall, div_start, div_annul, div_result_valid, div_ready_to_id, div_signed} !== 11'd0) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 0", {stall, div_start, div_annul, div_result_valid, div_ready_to_id, div_signed}); end
    checks++; if ({div_result_o, div_opdata1, div_opdata2} !== 128'd0) begin errors++; $display("FAIL rst_async_data: got %h expected 0", {div_result_o, div_opdata1, div_opdata2}); end
    tick(); rst = 1'b1;
    @(negedge clk);
    checks++; if ({div_annul, div_start, stall} !== 8'd0) begin errors++; $display("FAIL rst_release: got %b expected 0", {div_annul, div_start, stall}); end
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_normal_div();
    test_div_by_zero();
    test_flush();
    test_simultaneous();
    test_timeout();
    test_reset_mid_on();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
